// File: rtl/aes_key_expander_if.sv
// Key-load strobe, status and dual round-key read ports
// for the AES-128 key expander.
interface aes_key_expander_if;
  logic         set_key;
  logic [127:0] key;
  logic         busy;
  logic         key_ready;
  logic [3:0]   rk_idx_enc;
  logic [127:0] rk_enc;
  logic [3:0]   rk_idx_dec;
  logic [127:0] rk_dec;

  modport master (
    output set_key, key, rk_idx_enc, rk_idx_dec,
    input  busy, key_ready, rk_enc, rk_dec
  );

  modport slave (
    input  set_key, key, rk_idx_enc, rk_idx_dec,
    output busy, key_ready, rk_enc, rk_dec
  );
endinterface

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule: one round key per clock
// into an 11-entry register file with two read ports.
module aes_key_expander #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic               clk,
  input  logic               reset,
  aes_key_expander_if.slave  bus
);
  localparam int NK = NUM_ROUNDS + 1;
  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY
  } state_e;

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         busy_q, busy_d;
  logic         ready_q, ready_d;
  logic [127:0] rk_q [NK];
  logic [127:0] rk_d [NK];

  logic [127:0] prev;
  logic [31:0]  t, n0, n1, n2, n3;

  function automatic logic [31:0] sub_word(
    input logic [31:0] w
  );
    return {SBOX[w[31:24]], SBOX[w[23:16]],
            SBOX[w[15:8]],  SBOX[w[7:0]]};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rcon_d  = rcon_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    rk_d    = rk_q;

    prev = '0;
    if (cnt_q != 4'd0 && cnt_q <= LAST)
      prev = rk_q[cnt_q - 4'd1];

    // RotWord folded into the byte order fed to SubWord
    t  = sub_word({prev[23:0], prev[31:24]})
       ^ {rcon_q, 24'h0};
    n0 = prev[127:96] ^ t;
    n1 = prev[95:64]  ^ n0;
    n2 = prev[63:32]  ^ n1;
    n3 = prev[31:0]   ^ n2;

    if (bus.set_key) begin
      rk_d[0] = bus.key;
      cnt_d   = 4'd1;
      rcon_d  = 8'h01;
      busy_d  = 1'b1;
      ready_d = 1'b0;
      state_d = EXPAND;
    end else if (state_q == EXPAND) begin
      rk_d[cnt_q] = {n0, n1, n2, n3};
      cnt_d  = cnt_q + 4'd1;
      rcon_d = {rcon_q[6:0], 1'b0}
             ^ (rcon_q[7] ? 8'h1b : 8'h00);
      if (cnt_q == LAST) begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
        state_d = READY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rcon_q  <= 8'h01;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      rk_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcon_q  <= rcon_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      rk_q    <= rk_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.key_ready = ready_q;
  assign bus.rk_enc = (bus.rk_idx_enc <= LAST)
                    ? rk_q[bus.rk_idx_enc] : '0;
  assign bus.rk_dec = (bus.rk_idx_dec <= LAST)
                    ? rk_q[bus.rk_idx_dec] : '0;
endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Iterative AES-128 key-schedule unit that sits directly upstream of `aes_core`. It latches a 128-bit cipher key and expands it into round keys 0..10, generating one round key per clock. It holds all eleven keys in an internal register file. Two independent combinational read ports serve the encryption datapath (forward order) and the decryption datapath (reverse order).

## Interface
Parameters:
- `NUM_ROUNDS`, default 10: number of expansion rounds. Only 10 (AES-128) is supported; the register file holds `NUM_ROUNDS+1` keys.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `set_key`  in  1  one-cycle strobe: load `key` and start expansion.
- `key`  in  128  cipher key, sampled only when `set_key`=1.
- `busy`  out  1  expansion in progress.
- `key_ready`  out  1  all round keys 0..10 are valid for the current key.
- `rk_idx_enc`  in  4  round-key index for the encryption datapath.
- `rk_enc`  out  128  round key at `rk_idx_enc`; combinational read.
- `rk_idx_dec`  in  4  round-key index for the decryption datapath.
- `rk_dec`  out  128  round key at `rk_idx_dec`; combinational read.

## Operation
- Storage: `rk[0..10]`, 128 bits each, word order {w0,w1,w2,w3} with w0 at bits [127:96].
- FSM states and transitions:
  - IDLE → EXPAND on `set_key`.
  - EXPAND → READY after `rk[10]` is written.
  - READY → EXPAND on `set_key`.
  - EXPAND → EXPAND (restart) on `set_key`.
- On `set_key`:
  - `rk[0]` <= `key`.
  - Round counter `cnt` <= 1.
  - `rcon` <= 8'h01.
  - `key_ready` <= 0, `busy` <= 1.
  - State <= EXPAND.
- Each EXPAND cycle computes `rk[cnt]` from `rk[cnt-1]`:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
  - Then `cnt` <= `cnt`+1 and `rcon` <= xtime(`rcon`), i.e. shift left 1 and XOR 8'h1b if bit 7 was set.
- Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- SubWord uses four parallel instances of the standard AES forward S-box, in-block combinational LUT.
- When `cnt`=10 is written: state <= READY, `busy` <= 0, `key_ready` <= 1.
- Read ports:
  - `rk_enc` = `rk[rk_idx_enc]` and `rk_dec` = `rk[rk_idx_dec]`, purely combinational.
  - Index 11..15 returns 128'h0.
  - Both ports may read the same index in the same cycle.
- `set_key` during EXPAND aborts the current expansion and restarts from the new key next edge. Partially written old keys may remain readable but `key_ready` stays 0 until the new expansion completes.
- `set_key` in READY drops `key_ready` at that edge and restarts.
- `reset` has priority over `set_key`.

## Timing
- Reset values after the edge with `reset`=1:
  - state IDLE, `cnt`=0, `rcon`=8'h01.
  - All `rk[*]`=0.
  - `busy`=0, `key_ready`=0.
  - `rk_enc` = `rk_dec` = 128'h0 for any index.
- Cycle numbering: `set_key` is sampled at edge E0. `rk[0]` is valid after E0. `rk[k]` is written at edge Ek, for k=1..10.
- `busy` is high from after E0 through E10. It is low after E10.
- `key_ready` rises after E10. Total latency from strobe to ready is 10 clocks.
- `key_ready` and `busy` are never simultaneously 1.
- Consumers must not start encryption or decryption until `key_ready`=1. The block has no backpressure and accepts `set_key` in any state.
- Reset mid-expansion: at the reset edge all storage clears, `busy` and `key_ready` go 0, and no further writes occur.
- Register-file writes happen only at EXPAND edges and at the `set_key` edge (for `rk[0]`). Reads reflect a write in the cycle after its edge.

## Test plan
- FIPS-197 key:
  - Stimulus: `set_key` with `key`=2b7e151628aed2a6abf7158809cf4f3c.
  - `key_ready` rises exactly 10 clocks after E0.
  - `rk[0]` = the key.
  - `rk[1]` = a0fafe1788542cb123a339392a6c7605.
  - `rk[2]` = f2c295f27a96b9435935807a7359f67f.
  - `rk[10]` = d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key:
  - `rk[1]` = 62636363626363636263636362636363.
  - `rk[10]` = b4ef5bcb3e92e21123e951cf6f8f188e.
  - `busy` is high for exactly 10 cycles.
- Dual read: after ready, set `rk_idx_enc`=0 and `rk_idx_dec`=10 in the same cycle.
  - Both outputs match the FIPS-197 values in the same cycle.
  - Index 12 returns 0.
- Restart mid-expansion:
  - Load the zero key, then at E4 strobe the FIPS-197 key.
  - `key_ready` stays 0 until 10 clocks after the second strobe.
  - `rk[10]` = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Reset mid-expansion:
  - Assert `reset` at E5. Next cycle `busy`=0, `key_ready`=0, and `rk_enc` (idx 0) = 0.
  - A new `set_key` then completes normally.
- Rekey from READY: strobe a new key while `key_ready`=1.
  - `key_ready` falls after that edge.
  - `key_ready` reasserts 10 clocks later with the new schedule.
